axicb_id_order_ctrl: RTL and testbench
======================================

AXICB_ID_ORDER_CTRL -- requirements
Module: axicb_id_order_ctrl

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 8: AXI ID width in bits.
REQ-002 SHALL have parameter SLV_NB, default 4: number of slaves.
REQ-003 SHALL have parameter MST_OSTDREQ_NUM, default 4: number of tracked IDs; ID index width IDX_W=max(1,$clog2(MST_OSTDREQ_NUM)).
REQ-004 SHALL have parameter MAX_PER_ID, default 4: max outstanding per ID, 1..255.
REQ-005 SHALL have parameter [AXI_ID_W-1:0] MST_ID_MASK, default 'h00: master ID mask.
REQ-006 SHALL have ports, one per line:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous active-high reset
s_valid  in  1  address request from master
s_ready  out  1  address accept to master
s_id  in  AXI_ID_W  request ID
s_ix  in  SLV_NB  one-hot target slave
s_mr  in  1  misrouted flag
m_valid  out  1  request forwarded to router
m_ready  in  1  router accept
c_valid  in  1  completion beat valid
c_ready  in  1  completion beat accepted
c_last  in  1  last completion beat
c_id  in  AXI_ID_W  completion ID
busy  out  1  any ID outstanding
err  out  1  sticky completion-underflow flag

Function
REQ-007 SHALL compute idx=(s_id^MST_ID_MASK)[IDX_W-1:0] and cidx=(c_id^MST_ID_MASK)[IDX_W-1:0].
REQ-008 SHALL keep per ID a counter cnt (8 bits) and a destination register dst ({s_mr,s_ix}, SLV_NB+1 bits).
REQ-009 SHALL assert stall when cnt[idx]==MAX_PER_ID, or cnt[idx]!=0 and dst[idx]!={s_mr,s_ix}.
REQ-010 SHALL drive m_valid=s_valid&!stall and s_ready=m_ready&!stall combinationally, zero latency; s_ready SHALL NOT depend on s_valid.
REQ-011 SHALL define push=s_valid&m_ready&!stall and pop=c_valid&c_ready&c_last.
REQ-012 On push, SHALL load dst[idx] and increment cnt[idx] at the next edge.
REQ-013 On pop with cnt[cidx]!=0, SHALL decrement cnt[cidx] at the next edge; non-last beats SHALL have no effect.
REQ-014 Push and pop on the same ID in one cycle SHALL leave cnt unchanged and load dst; on different IDs both SHALL apply.
REQ-015 Pop with cnt[cidx]==0 SHALL leave cnt at 0 (no wrap) and flag underflow.
REQ-016 cnt SHALL never exceed MAX_PER_ID; dst SHALL be ignored while cnt==0.
REQ-017 busy SHALL be registered, equal to OR of (cnt!=0), updated one cycle after the count change.
REQ-018 Per-ID behaviour: tracker states IDLE (cnt 0), ACTIVE (0<cnt<MAX), FULL (cnt==MAX); IDLE->ACTIVE on push, ACTIVE->FULL on push at MAX-1, FULL->ACTIVE on pop, ACTIVE->IDLE on pop at 1.

Reset
REQ-019 aresetn low SHALL asynchronously clear all cnt, dst, busy and err to 0.
REQ-020 srst high SHALL synchronously clear the same state; outstanding transactions are discarded, not completed.
REQ-021 During reset, s_ready and m_valid SHALL follow REQ-010 with all counters at 0 (no stall).

Configuration
REQ-022 With AXICB_ID_ORDER_CHK_EN defined, err SHALL set on any underflow pop and hold until reset.
REQ-023 Without AXICB_ID_ORDER_CHK_EN, err SHALL be tied 0, underflow still saturates at 0, and no flag register SHALL be built.

Structure
REQ-024 Shared package axicb_pkg SHALL hold the tracker state enum (IDLE/ACTIVE/FULL) and the 8-bit count typedef.
REQ-025 Per-ID counter and dst logic SHALL be one sub-module, axicb_id_tracker, generated MST_OSTDREQ_NUM times.

Verification
REQ-026 Reset with no traffic: s_valid=1, s_id=0, s_ix=4'b0001, m_ready=1 -> m_valid=1 and s_ready=1 in the same cycle, cnt[0]=1 next cycle, busy=1 the cycle after.
REQ-027 Four pushes on ID 2 to slave 1 with MAX_PER_ID=4 -> fifth stalls (s_ready=0, m_valid=0); one last-beat pop on ID 2 -> fifth accepted the cycle after.
REQ-028 ID 1 outstanding to slave 0, new ID 1 request to slave 2 -> stalled until the last pop, then forwarded; an ID 3 request to slave 2 meanwhile -> forwarded immediately.
REQ-029 Same-cycle push and last-beat pop on ID 0 with cnt=2 -> cnt remains 2; non-last beats (c_last=0) -> cnt unchanged.
REQ-030 Pop on ID 3 with cnt=0 -> cnt stays 0; err=1 next cycle with AXICB_ID_ORDER_CHK_EN, err=0 without.
REQ-031 aresetn deasserted mid-traffic with cnt=3 on ID 0 -> all counts 0, busy=0, err=0 immediately, request to a different slave accepted next cycle.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared types for the AXI crossbar ID ordering logic: tracker state and the
// per-ID outstanding count.
package axicb_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } trk_state_e;

endpackage

// File: rtl/axicb_id_tracker.sv
// One AXI ID's outstanding-request tracker: count of in-flight requests plus
// the destination they were routed to, with IDLE/ACTIVE/FULL occupancy state.
module axicb_id_tracker
  import axicb_pkg::*;
#(
  parameter int unsigned DST_W      = 5,
  parameter int unsigned MAX_PER_ID = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [DST_W-1:0] dst_in,
  output logic [CNT_W-1:0] cnt,
  output logic [DST_W-1:0] dst,
  output logic             full
);

  localparam cnt_t MAX_CNT = CNT_W'(MAX_PER_ID);

  trk_state_e       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic             inc, dec;

  // Simultaneous push and pop cancel; a pop with nothing outstanding is dropped.
  assign inc = push && (state_q != FULL) && !(pop && (state_q != IDLE));
  assign dec = pop && (state_q != IDLE) && !push;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
    end else if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    if (push) begin
      dst_d = dst_in;
    end
    if (inc) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_d == MAX_CNT) ? FULL : ACTIVE;
    end else if (dec) begin
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = (cnt_d == '0) ? IDLE : ACTIVE;
    end
  end

  assign cnt  = cnt_q;
  assign dst  = dst_q;
  assign full = (state_q == FULL);

endmodule

// File: rtl/axicb_id_order_ctrl.sv
// Per-ID ordering gate between an AXI master and the crossbar router: stalls a
// request while its ID is saturated or still outstanding to a different slave.
// Define AXICB_ID_ORDER_CHK_EN to build the sticky completion-underflow flag.
module axicb_id_order_ctrl
  import axicb_pkg::*;
#(
  parameter int unsigned         AXI_ID_W        = 8,
  parameter int unsigned         SLV_NB          = 4,
  parameter int unsigned         MST_OSTDREQ_NUM = 4,
  parameter int unsigned         MAX_PER_ID      = 4,
  parameter logic [AXI_ID_W-1:0] MST_ID_MASK     = '0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                srst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [AXI_ID_W-1:0] s_id,
  input  logic [SLV_NB-1:0]   s_ix,
  input  logic                s_mr,
  output logic                m_valid,
  input  logic                m_ready,
  input  logic                c_valid,
  input  logic                c_ready,
  input  logic                c_last,
  input  logic [AXI_ID_W-1:0] c_id,
  output logic                busy,
  output logic                err
);

  localparam int unsigned IDX_W = (MST_OSTDREQ_NUM > 1) ? $clog2(MST_OSTDREQ_NUM) : 1;
  localparam int unsigned IDX_N = 1 << IDX_W;
  localparam int unsigned DST_W = SLV_NB + 1;

  logic [IDX_W-1:0] idx, cidx;
  logic [DST_W-1:0] req_dst;
  cnt_t             cnt [IDX_N];
  logic [DST_W-1:0] dst [IDX_N];
  logic [IDX_N-1:0] full, live;
  logic             stall, push, pop;

  assign idx     = IDX_W'(s_id ^ MST_ID_MASK);
  assign cidx    = IDX_W'(c_id ^ MST_ID_MASK);
  assign req_dst = {s_mr, s_ix};

  assign stall   = full[idx] || ((cnt[idx] != '0) && (dst[idx] != req_dst));
  assign m_valid = s_valid && !stall;
  assign s_ready = m_ready && !stall;
  assign push    = s_valid && m_ready && !stall;
  assign pop     = c_valid && c_ready && c_last;

  // Index slots beyond MST_OSTDREQ_NUM never hold anything.
  for (genvar i = 0; i < IDX_N; i++) begin : g_trk
    if (i < MST_OSTDREQ_NUM) begin : g_on
      axicb_id_tracker #(
        .DST_W      (DST_W),
        .MAX_PER_ID (MAX_PER_ID)
      ) u_trk (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .push    (push && (idx == IDX_W'(i))),
        .pop     (pop && (cidx == IDX_W'(i))),
        .dst_in  (req_dst),
        .cnt     (cnt[i]),
        .dst     (dst[i]),
        .full    (full[i])
      );
    end else begin : g_off
      assign cnt[i]  = '0;
      assign dst[i]  = '0;
      assign full[i] = 1'b0;
    end
    assign live[i] = (cnt[i] != '0);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy <= 1'b0;
    end else if (srst) begin
      busy <= 1'b0;
    end else begin
      busy <= |live;
    end
  end

`ifdef AXICB_ID_ORDER_CHK_EN
  logic underflow;

  assign underflow = pop && (cnt[cidx] == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err <= 1'b0;
    end else if (srst) begin
      err <= 1'b0;
    end else if (underflow) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_id_order_ctrl.sv
// Directed scoreboard bench for axicb_id_order_ctrl: each stimulus cycle queues
// its expected handshake/status outputs, a monitor checks them mid-cycle.
module tb_axicb_id_order_ctrl;

  localparam int unsigned AXI_ID_W = 8;
  localparam int unsigned SLV_NB   = 4;

`ifdef AXICB_ID_ORDER_CHK_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic                aclk;
  logic                aresetn;
  logic                srst;
  logic                s_valid;
  logic                s_ready;
  logic [AXI_ID_W-1:0] s_id;
  logic [SLV_NB-1:0]   s_ix;
  logic                s_mr;
  logic                m_valid;
  logic                m_ready;
  logic                c_valid;
  logic                c_ready;
  logic                c_last;
  logic [AXI_ID_W-1:0] c_id;
  logic                busy;
  logic                err;

  axicb_id_order_ctrl #(
    .AXI_ID_W        (AXI_ID_W),
    .SLV_NB          (SLV_NB),
    .MST_OSTDREQ_NUM (4),
    .MAX_PER_ID      (4),
    .MST_ID_MASK     (8'h00)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_id    (s_id),
    .s_ix    (s_ix),
    .s_mr    (s_mr),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_last  (c_last),
    .c_id    (c_id),
    .busy    (busy),
    .err     (err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string nm;
    bit    mv;
    bit    sr;
    bit    bsy;
    bit    er;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input string fld, input logic act, input bit want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s.%s got %b want %b", nm, fld, act, want);
    end
  endtask

  // Monitor: outputs are compared on the falling edge of the cycle they belong to.
  always @(negedge aclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.nm, "m_valid", m_valid, e.mv);
      chk(e.nm, "s_ready", s_ready, e.sr);
      chk(e.nm, "busy",    busy,    e.bsy);
      chk(e.nm, "err",     err,     e.er);
    end
  end

  task automatic step(input string nm, input bit rstn, input bit sr_st,
                      input bit sv, input int id, input bit [3:0] ix, input bit mr,
                      input bit mrdy, input bit cv, input bit cr, input bit cl, input int cid,
                      input bit emv, input bit esr, input bit ebusy, input bit eerr);
    exp_t e;
    @(posedge aclk);
    #1;
    aresetn = rstn;
    srst    = sr_st;
    s_valid = sv;
    s_id    = AXI_ID_W'(id);
    s_ix    = ix;
    s_mr    = mr;
    m_ready = mrdy;
    c_valid = cv;
    c_ready = cr;
    c_last  = cl;
    c_id    = AXI_ID_W'(cid);
    e.nm = nm; e.mv = emv; e.sr = esr; e.bsy = ebusy; e.er = eerr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input bit ebusy, input bit eerr);
    step(nm, 1, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 1, ebusy, eerr);
  endtask

  task automatic req(input string nm, input int id, input bit [3:0] ix, input bit mr,
                     input bit emv, input bit esr, input bit ebusy, input bit eerr);
    step(nm, 1, 0, 1, id, ix, mr, 1, 0, 0, 0, 0, emv, esr, ebusy, eerr);
  endtask

  task automatic pop(input string nm, input int cid, input int sid, input bit ebusy, input bit eerr);
    step(nm, 1, 0, 0, sid, 4'b0001, 0, 1, 1, 1, 1, cid, 0, 1, ebusy, eerr);
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0; s_valid = 1'b0; s_id = '0; s_ix = '0; s_mr = 1'b0;
    m_ready = 1'b0; c_valid = 1'b0; c_ready = 1'b0; c_last = 1'b0; c_id = '0;
    repeat (2) @(posedge aclk);

    // Handshake passes through during reset with counters at zero
    step("rst_pass", 0, 0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle("rel", 0, 0);

    // First request, then busy one cycle after the count moves
    req ("t1_push", 0, 4'b0001, 0, 1, 1, 0, 0);
    idle("t2", 0, 0);
    idle("t3_busy", 1, 0);
    pop ("t4_pop", 0, 0, 1, 0);
    idle("t5", 1, 0);
    idle("t6_clear", 0, 0);

    // Saturate ID 2, fifth stalls, released one cycle after a last-beat pop
    req ("p1", 2, 4'b0010, 0, 1, 1, 0, 0);
    req ("p2", 2, 4'b0010, 0, 1, 1, 0, 0);
    req ("p3", 2, 4'b0010, 0, 1, 1, 1, 0);
    req ("p4", 2, 4'b0010, 0, 1, 1, 1, 0);
    req ("p5_full", 2, 4'b0010, 0, 0, 0, 1, 0);
    step("p6_full_pop", 1, 0, 1, 2, 4'b0010, 0, 1, 1, 1, 1, 2, 0, 0, 1, 0);
    req ("p7_accept", 2, 4'b0010, 0, 1, 1, 1, 0);
    pop ("d1", 2, 0, 1, 0);
    pop ("d2", 2, 0, 1, 0);
    pop ("d3", 2, 0, 1, 0);
    pop ("d4", 2, 0, 1, 0);
    idle("e1", 1, 0);
    idle("e2", 0, 0);

    // Destination change on ID 1 waits; ID 3 unaffected
    req ("q1", 1, 4'b0001, 0, 1, 1, 0, 0);
    req ("q2_dst_stall", 1, 4'b0100, 0, 0, 0, 0, 0);
    req ("q3_other_id", 3, 4'b0100, 0, 1, 1, 1, 0);
    step("q4_stall_pop", 1, 0, 1, 1, 4'b0100, 0, 1, 1, 1, 1, 1, 0, 0, 1, 0);
    req ("q5_fwd", 1, 4'b0100, 0, 1, 1, 1, 0);
    req ("q6_same_dst", 1, 4'b0100, 0, 1, 1, 1, 0);
    pop ("q7", 1, 0, 1, 0);
    pop ("q8", 1, 0, 1, 0);
    pop ("q9", 3, 0, 1, 0);
    idle("q10", 1, 0);
    idle("q11", 0, 0);

    // Same-cycle push/pop and non-last beats leave the count at 2
    req ("r1", 0, 4'b0001, 0, 1, 1, 0, 0);
    req ("r2", 0, 4'b0001, 0, 1, 1, 0, 0);
    step("r3_push_pop", 1, 0, 1, 0, 4'b0001, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0);
    step("r4_not_last", 1, 0, 0, 0, 4'b0001, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    step("r5_not_ready", 1, 0, 0, 0, 4'b0001, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0);
    req ("r6_mr_stall", 0, 4'b0001, 1, 0, 0, 1, 0);
    req ("r7_cnt3", 0, 4'b0001, 0, 1, 1, 1, 0);

    // Asynchronous reset mid-traffic clears everything at once
    step("r8_arst", 0, 0, 1, 0, 4'b0010, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    req ("r9_new_dst", 0, 4'b0010, 0, 1, 1, 0, 0);
    req ("r10", 0, 4'b0010, 0, 1, 1, 0, 0);
    req ("r11_old_dst", 0, 4'b0001, 0, 0, 0, 1, 0);
    pop ("r12", 0, 3, 1, 0);
    pop ("r13", 0, 3, 1, 0);
    idle("r14", 1, 0);
    idle("r15", 0, 0);

    // Underflow pop saturates at zero and raises the sticky flag when built
    pop ("u1_under", 3, 0, 0, 0);
    idle("u2_err", 0, E);
    idle("u3_sticky", 0, E);
    req ("u4_no_wrap", 3, 4'b0001, 0, 1, 1, 0, E);
    req ("u5", 3, 4'b0001, 0, 1, 1, 0, E);

    // Synchronous reset discards outstanding state and the flag
    step("s1_srst", 1, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 1, 1, E);
    req ("s2_after", 3, 4'b0100, 0, 1, 1, 0, 0);
    pop ("s3", 3, 0, 0, 0);
    idle("s4", 1, 0);
    idle("s5", 0, 0);

    repeat (4) @(posedge aclk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
